mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous single-port memory between the fetch stage (I port, read-only)
//  and the load/store unit (D port, read/write). At most one transaction is outstanding;
//  each response is routed back to the requester that owns it. D has priority, and a
//  streak limit guarantees I is not starved. A kill input discards an in-flight fetch on redirect.
// PARAMETERS
//  ADDR_W       32  byte-address width of all address ports
//  DATA_W       32  data width; byte enables are DATA_W/8 bits
//  MAX_DSTREAK  4   max consecutive D grants while i_req is pending (legal 1..15)
// PORTS
//  clk         in   1         clock, all state on rising edge
//  resetn      in   1         asynchronous active-low reset
//  i_req       in   1         fetch request; held with i_addr stable until i_gnt
//  i_addr      in   ADDR_W    fetch address
//  i_kill      in   1         discard outstanding/granting-this-cycle fetch response
//  i_gnt       out  1         fetch request accepted this cycle
//  i_rvalid    out  1         fetch data valid
//  i_rdata     out  DATA_W    fetch data
//  d_req       in   1         load/store request; held with d_* stable until d_gnt
//  d_we        in   1         1 = store, 0 = load
//  d_be        in   DATA_W/8  store byte enables
//  d_addr      in   ADDR_W    load/store address
//  d_wdata     in   DATA_W    store data
//  d_gnt       out  1         load/store request accepted this cycle
//  d_rvalid    out  1         load data valid / store complete
//  d_rdata     out  DATA_W    load data (don't-care for stores)
//  mem_req     out  1         memory request
//  mem_we      out  1         memory write enable
//  mem_be      out  DATA_W/8  memory byte enables (all ones for fetch)
//  mem_addr    out  ADDR_W    memory address
//  mem_wdata   out  DATA_W    memory write data
//  mem_gnt     in   1         memory accepts request this cycle
//  mem_rvalid  in   1         response for accepted request (reads and writes)
//  mem_rdata   in   DATA_W    memory read data
// BEHAVIOUR
//  - State: IDLE / BUSY, plus owner (I|D), kill flag, streak counter (4 bits).
//  - Reset (async): IDLE, owner=I, kill=0, streak=0; i_gnt, d_gnt, i_rvalid, d_rvalid,
//    mem_req = 0 and all outputs take their idle values while resetn is low.
//  - Issue window = IDLE, or BUSY in the cycle mem_rvalid=1 (back-to-back issue).
//  - Selection in issue window: only one requester -> that one. Both -> D, unless
//    streak==MAX_DSTREAK, then I. Outside issue window: mem_req=0.
//  - mem_* driven combinationally from the selected requester; mem_we=0 and mem_be='1 for I.
//  - x_gnt = selected & mem_req & mem_gnt (same cycle). On grant: BUSY, owner latched,
//    kill cleared; if the grant is to I with i_kill high that cycle, kill is set instead.
//  - Without mem_gnt the request stays presented; the selection may change next cycle.
//  - Streak: D grant while i_req=1 -> +1 (saturate at MAX_DSTREAK); I grant or i_req=0 -> 0.
//  - Response: mem_rvalid in BUSY -> owner's x_rvalid=1 same cycle, x_rdata=mem_rdata;
//    i_rvalid suppressed if kill set or i_kill=1 this cycle. BUSY->IDLE unless new grant.
//  - i_kill in BUSY with owner=I sets kill; it has no effect otherwise and never affects D.
//  - mem_rvalid in IDLE is ignored (stale response after reset).
//  - Latency: grant in cycle N, earliest rvalid N+1; full throughput is 1 transaction/cycle.
//  - Reset mid-transaction drops the outstanding transaction; neither rvalid fires.
// TESTING
//  1. Lone fetch, mem_gnt=1 always, i_addr=0x100 -> i_gnt cycle N, i_rvalid N+1 with
//     mem_rdata; mem_be=4'hF, mem_we=0.
//  2. i_req and d_req held continuously with MAX_DSTREAK=4 -> grant pattern D,D,D,D,I
//     repeating; one grant per cycle, no cycle without mem_req.
//  3. Store d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_* match exactly;
//     d_rvalid on ack; i_rvalid stays 0.
//  4. Fetch granted, i_kill=1 in the following cycle, mem_rvalid next -> i_rvalid stays 0;
//     a D request pending in the same cycle is granted back-to-back.
//  5. mem_gnt=0 for 3 cycles with d_req held -> d_gnt=0 and mem_req=1 throughout;
//     grant in cycle 4.
//  6. resetn low while BUSY, then mem_rvalid=1 after release -> no x_rvalid, IDLE, streak=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between a fetch (I) port and a load/store (D) port
// At most one transaction in flight; D has priority, bounded by a streak limit so fetch is never starved.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic       owner_d;
  logic       kill;
  logic [3:0] streak;

  logic resp;
  logic issue_win;
  logic sel_d;

  always_comb begin
    resp      = (state == BUSY) && mem_rvalid;
    // A response frees the memory, so a new request can issue in the same cycle.
    issue_win = (state == IDLE) || resp;
    sel_d     = d_req && (!i_req || (streak != STREAK_MAX));

    mem_req   = resetn && issue_win && (i_req || d_req);
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (sel_d) begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_be    = {BE_W{1'b1}};
        mem_addr  = i_addr;
      end
    end

    d_gnt    = mem_req && mem_gnt && sel_d;
    i_gnt    = mem_req && mem_gnt && !sel_d;

    d_rvalid = resp && owner_d;
    i_rvalid = resp && !owner_d && !kill && !i_kill;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    i_rdata  = i_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      kill    <= 1'b0;
      streak  <= 4'd0;
    end else begin
      if (i_gnt || d_gnt) begin
        state   <= BUSY;
        owner_d <= d_gnt;
        kill    <= i_gnt && i_kill;
      end else begin
        if (resp) state <= IDLE;
        // A redirect while a fetch is outstanding poisons its eventual response.
        if ((state == BUSY) && !owner_d && i_kill) kill <= 1'b1;
      end

      if (!i_req || i_gnt) begin
        streak <= 4'd0;
      end else if (d_gnt && (streak != STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with response scoreboard for mem_port_arbiter
// The memory model answers every accepted request one cycle later with data = addr ^ 0x5A5A0000.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_kill, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic [31:0] exp_i[$];
  exp_t        exp_d[$];

  bit auto_resp = 1'b1;
  bit force_rv  = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Memory model: capture accepted request mid-cycle, respond after the next edge.
  initial begin
    logic        pend, nxt, p_we, n_we;
    logic [31:0] p_addr, n_addr;
    pend = 1'b0; p_we = 1'b0; p_addr = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      nxt = pend; n_we = p_we; n_addr = p_addr;
      if (mem_rvalid) nxt = 1'b0;
      if (mem_req && mem_gnt) begin
        nxt = 1'b1; n_we = mem_we; n_addr = mem_addr;
      end
      @(posedge clk);
      #2;
      pend = nxt; p_we = n_we; p_addr = n_addr;
      mem_rvalid = pend && (auto_resp || force_rv);
      mem_rdata  = p_we ? 32'h0 : (p_addr ^ 32'h5A5A_0000);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (i_rvalid) begin
        total++;
        if (exp_i.size() == 0) begin
          bad++;
          $display("FAIL i_rvalid_unexpected actual=1 required=0 rdata=%h", i_rdata);
        end else begin
          logic [31:0] e;
          e = exp_i.pop_front();
          if (i_rdata !== e) begin
            bad++;
            $display("FAIL i_rdata actual=%h required=%h", i_rdata, e);
          end
        end
      end
      if (d_rvalid) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++;
          $display("FAIL d_rvalid_unexpected actual=1 required=0 rdata=%h", d_rdata);
        end else begin
          exp_t e;
          e = exp_d.pop_front();
          if (e.chk && (d_rdata !== e.data)) begin
            bad++;
            $display("FAIL d_rdata actual=%h required=%h", d_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_d(input bit c, input logic [31:0] v);
    exp_t e;
    e.chk = c;
    e.data = v;
    exp_d.push_back(e);
  endtask

  // Both ports held: expected grants D,D,D,D,I repeating from streak 0.
  task automatic run_pattern(input int n);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF;
    for (int k = 0; k < n; k++) begin
      bit want_i;
      want_i = ((k % 5) == 4);
      @(negedge clk);
      chk1("pat_mem_req", mem_req, 1'b1);
      chk1("pat_i_gnt", i_gnt, want_i);
      chk1("pat_d_gnt", d_gnt, !want_i);
      if (want_i) exp_i.push_back(32'h5A5A_0200);
      else        push_d(1'b1, 32'h5A5A_0300);
      step();
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; i_kill = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
    mem_gnt = 1'b1;

    // Reset state: requests present but everything held idle.
    step(); step();
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_i_rvalid", i_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    step();
    resetn = 1'b1; i_req = 1'b0; d_req = 1'b0;
    step();

    // 1: lone fetch.
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk1("t1_i_gnt", i_gnt, 1'b1);
    chk1("t1_d_gnt", d_gnt, 1'b0);
    chk1("t1_mem_we", mem_we, 1'b0);
    chk32("t1_mem_be", {28'h0, mem_be}, 32'hF);
    chk32("t1_mem_addr", mem_addr, 32'h100);
    exp_i.push_back(32'h5A5A_0100);
    step();
    i_req = 1'b0;
    @(negedge clk);
    chk1("t1_i_rvalid", i_rvalid, 1'b1);
    step(); step();

    // 2: contention pattern.
    run_pattern(10);
    step(); step();

    // 3: store.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("t3_d_gnt", d_gnt, 1'b1);
    chk1("t3_mem_we", mem_we, 1'b1);
    chk32("t3_mem_be", {28'h0, mem_be}, 32'h3);
    chk32("t3_mem_addr", mem_addr, 32'h40);
    chk32("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    push_d(1'b0, 32'h0);
    step();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    @(negedge clk);
    chk1("t3_d_rvalid", d_rvalid, 1'b1);
    chk1("t3_i_rvalid", i_rvalid, 1'b0);
    step(); step();

    // 4: fetch killed while outstanding, D issues back-to-back on its response.
    i_req = 1'b1; i_addr = 32'h180; auto_resp = 1'b0;
    @(negedge clk);
    chk1("t4_i_gnt", i_gnt, 1'b1);
    step();
    i_req = 1'b0; i_kill = 1'b1;
    d_req = 1'b1; d_addr = 32'h84;
    @(negedge clk);
    chk1("t4_d_gnt_busy", d_gnt, 1'b0);
    chk1("t4_i_rvalid_wait", i_rvalid, 1'b0);
    step();
    i_kill = 1'b0; auto_resp = 1'b1;
    @(negedge clk);
    chk1("t4_mem_rvalid", mem_rvalid, 1'b1);
    chk1("t4_i_rvalid_killed", i_rvalid, 1'b0);
    chk1("t4_d_gnt_b2b", d_gnt, 1'b1);
    push_d(1'b1, 32'h5A5A_0084);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk1("t4_d_rvalid", d_rvalid, 1'b1);
    step(); step();

    // 5: memory stalls grant for 3 cycles.
    d_req = 1'b1; d_addr = 32'h88; mem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t5_mem_req_stall", mem_req, 1'b1);
      chk1("t5_d_gnt_stall", d_gnt, 1'b0);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk1("t5_d_gnt", d_gnt, 1'b1);
    push_d(1'b1, 32'h5A5A_0088);
    step();
    d_req = 1'b0;
    step(); step();

    // 6: build a D streak, reset mid-transaction, stale response must be ignored.
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300;
    @(negedge clk);
    chk1("t6_d_gnt0", d_gnt, 1'b1);
    push_d(1'b1, 32'h5A5A_0300);
    step();
    @(negedge clk);
    chk1("t6_d_gnt1", d_gnt, 1'b1);
    step();
    auto_resp = 1'b0;
    @(negedge clk);
    chk1("t6_busy_no_req", mem_req, 1'b0);
    step();
    i_req = 1'b0; d_req = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk1("t6_rst_mem_req", mem_req, 1'b0);
    chk1("t6_rst_d_rvalid", d_rvalid, 1'b0);
    step();
    resetn = 1'b1;
    step();
    force_rv = 1'b1;
    @(negedge clk);
    chk1("t6_stale_mem_rvalid", mem_rvalid, 1'b1);
    chk1("t6_stale_i_rvalid", i_rvalid, 1'b0);
    chk1("t6_stale_d_rvalid", d_rvalid, 1'b0);
    step();
    force_rv = 1'b0; auto_resp = 1'b1;
    run_pattern(5);
    step(); step(); step();

    chk1("end_exp_i_empty", exp_i.size() == 0, 1'b1);
    chk1("end_exp_d_empty", exp_d.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
